// File: rtl/iopmp_err_capture.sv
// iopmp_err_capture: latches the first IOPMP violation into a software-visible error record
//   clk, rst                 clock, async active-high reset
//   req_valid_i              per-channel request qualifier
//   iopmp_error_report_i     per-channel checker report
//   entry_violated_index_i   per-channel violated entry index
//   err_clr_i                write-1 pulse to ERR_INFO.v
//   intr_en_i                ERR_CFG.ie
//   err_*_o                  held record, subsequent-violation flag/count
//   irq_o                    interrupt
package iopmp_err_pkg;
    parameter int SourceWidth = 8;
    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_ILLEGAL_READ  = 3'd1,
        ERR_ILLEGAL_WRITE = 3'd2,
        ERR_ILLEGAL_EXEC  = 3'd3,
        ERR_PARTIAL_HIT   = 3'd4,
        ERR_NOT_HIT       = 3'd5,
        ERR_UNKNOWN_RRID  = 3'd6
    } error_type;
    typedef enum logic [1:0] {
        TT_RSVD  = 2'd0,
        TT_READ  = 2'd1,
        TT_WRITE = 2'd2,
        TT_EXEC  = 2'd3
    } transaction_type;
    typedef struct packed {
        logic                   iopmp_fail;
        error_type              etype;
        transaction_type        ttype;
        logic [33:0]            reqaddr;
        logic [31:0]            reqaddrh;
        logic [SourceWidth-1:0] rrid;
        logic [8:0]             eid;
    } error_report_t;
endpackage

module iopmp_err_capture
    import iopmp_err_pkg::*;
#(
    parameter int IOPMPNumChan = 4,
    parameter int SvcWidth = 8,
    localparam int ChanIdxW = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IOPMPNumChan-1:0] req_valid_i,
    input  error_report_t          iopmp_error_report_i [IOPMPNumChan],
    input  logic [8:0]             entry_violated_index_i [IOPMPNumChan],
    input  logic                   err_clr_i,
    input  logic                   intr_en_i,
    output logic                   err_valid_o,
    output error_type              err_etype_o,
    output transaction_type        err_ttype_o,
    output logic [33:0]            err_reqaddr_o,
    output logic [31:0]            err_reqaddrh_o,
    output logic [SourceWidth-1:0] err_rrid_o,
    output logic [8:0]             err_eid_o,
    output logic [ChanIdxW-1:0]    err_chan_o,
    output logic                   err_svc_o,
    output logic [SvcWidth-1:0]    err_svc_cnt_o,
    output logic                   irq_o
);
    // Wide enough that adding a full cycle of failures to a saturated count cannot wrap.
    localparam int SumW = SvcWidth + ChanIdxW + 1;
    localparam logic [SumW-1:0] SvcSat = SumW'((1 << SvcWidth) - 1);

    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [IOPMPNumChan-1:0] fail;
    logic [ChanIdxW:0]     nfail;
    logic [ChanIdxW-1:0]   win;
    logic                  capture;
    logic [SvcWidth-1:0]   svc_q, svc_d;
    logic [SumW-1:0]       sum_cap, sum_held;
    logic                  unused_report_eid;

    function automatic logic [SvcWidth-1:0] sat(input logic [SumW-1:0] v);
        return (v > SvcSat) ? SvcSat[SvcWidth-1:0] : v[SvcWidth-1:0];
    endfunction

    always_comb begin
        fail = '0;
        nfail = '0;
        win = '0;
        unused_report_eid = 1'b0;
        for (int i = 0; i < IOPMPNumChan; i++) begin
            fail[i] = req_valid_i[i] & iopmp_error_report_i[i].iopmp_fail;
            nfail = nfail + (ChanIdxW+1)'(fail[i]);
            unused_report_eid = unused_report_eid ^ (^iopmp_error_report_i[i].eid);
        end
        // Descending scan so the lowest-indexed failing channel is the last to write.
        for (int i = IOPMPNumChan - 1; i >= 0; i--) begin
            if (fail[i]) win = ChanIdxW'(i);
        end
    end

    // A clear coincident with an event behaves as clear-then-capture, so nothing is lost.
    assign capture  = (nfail != '0) && (state_q == IDLE || err_clr_i);
    assign sum_cap  = SumW'(nfail) - SumW'(1);
    assign sum_held = SumW'(svc_q) + SumW'(nfail);

    always_comb begin
        state_d = capture ? HELD : (err_clr_i ? IDLE : state_q);
        svc_d = capture ? sat(sum_cap)
              : (state_q == HELD) ? (err_clr_i ? '0 : sat(sum_held))
              : svc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            svc_q          <= '0;
            err_etype_o    <= ERR_NONE;
            err_ttype_o    <= TT_RSVD;
            err_reqaddr_o  <= '0;
            err_reqaddrh_o <= '0;
            err_rrid_o     <= '0;
            err_eid_o      <= '0;
            err_chan_o     <= '0;
        end else begin
            state_q <= state_d;
            svc_q   <= svc_d;
            if (capture) begin
                err_etype_o    <= iopmp_error_report_i[win].etype;
                err_ttype_o    <= iopmp_error_report_i[win].ttype;
                err_reqaddr_o  <= iopmp_error_report_i[win].reqaddr;
                err_reqaddrh_o <= iopmp_error_report_i[win].reqaddrh;
                err_rrid_o     <= iopmp_error_report_i[win].rrid;
                err_eid_o      <= entry_violated_index_i[win];
                err_chan_o     <= win;
            end
        end
    end

    assign err_valid_o   = (state_q == HELD);
    assign err_svc_cnt_o = svc_q;
    assign err_svc_o     = (svc_q != '0);
    assign irq_o         = err_valid_o & intr_en_i;
endmodule

// File: tb/tb_iopmp_err_capture.sv
// tb_iopmp_err_capture: directed self-checking bench for iopmp_err_capture
module tb_iopmp_err_capture;
    import iopmp_err_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_valid;
    error_report_t   rep [4];
    logic [8:0]      evi [4];
    logic            err_clr;
    logic            intr_en;
    logic            err_valid;
    error_type       err_etype;
    transaction_type err_ttype;
    logic [33:0]     err_reqaddr;
    logic [31:0]     err_reqaddrh;
    logic [7:0]      err_rrid;
    logic [8:0]      err_eid;
    logic [1:0]      err_chan;
    logic            err_svc;
    logic [7:0]      err_svc_cnt;
    logic            irq;
    int              n_cmp = 0;
    int              n_fail = 0;

    iopmp_err_capture dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid),
        .iopmp_error_report_i(rep), .entry_violated_index_i(evi),
        .err_clr_i(err_clr), .intr_en_i(intr_en),
        .err_valid_o(err_valid), .err_etype_o(err_etype), .err_ttype_o(err_ttype),
        .err_reqaddr_o(err_reqaddr), .err_reqaddrh_o(err_reqaddrh), .err_rrid_o(err_rrid),
        .err_eid_o(err_eid), .err_chan_o(err_chan), .err_svc_o(err_svc),
        .err_svc_cnt_o(err_svc_cnt), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        err_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rep[i] = '0;
            evi[i] = '0;
        end
    endtask

    task automatic set_ev(input int ch, input logic valid, input logic [33:0] addr,
                          input logic [7:0] rrid, input logic [8:0] eid);
        req_valid[ch] = valid;
        rep[ch] = '{iopmp_fail: 1'b1, etype: ERR_ILLEGAL_WRITE, ttype: TT_WRITE,
                    reqaddr: addr, reqaddrh: 32'h0000_0002, rrid: rrid, eid: 9'h0AA};
        evi[ch] = eid;
    endtask

    task automatic test_reset();
        tick();
        n_cmp++;
        if ({err_valid, irq, err_svc, err_svc_cnt, err_chan, err_eid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b irq=%b svc=%b cnt=%0d chan=%0d eid=%h want all 0",
                     err_valid, irq, err_svc, err_svc_cnt, err_chan, err_eid);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (err_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_v: got %b want 0", err_valid);
        end
    endtask

    task automatic test_single();
        set_ev(2, 1'b1, 34'h0_8000_1000, 8'd5, 9'd7);
        tick();
        idle_inputs();
        n_cmp++;
        if ({err_valid, err_chan, err_reqaddr, err_rrid, err_eid, err_svc, err_svc_cnt, irq}
            !== {1'b1, 2'd2, 34'h0_8000_1000, 8'd5, 9'd7, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_record: got v=%b chan=%0d addr=%h rrid=%0d eid=%0d svc=%b cnt=%0d irq=%b want 1/2/080001000/5/7/0/0/1",
                     err_valid, err_chan, err_reqaddr, err_rrid, err_eid, err_svc, err_svc_cnt, irq);
        end
        n_cmp++;
        if ({err_etype, err_ttype, err_reqaddrh} !== {ERR_ILLEGAL_WRITE, TT_WRITE, 32'h0000_0002}) begin
            n_fail++;
            $display("FAIL single_types: got et=%0d tt=%0d addrh=%h want 2/2/00000002",
                     err_etype, err_ttype, err_reqaddrh);
        end
    endtask

    task automatic test_irq_enable();
        intr_en = 1'b0;
        #1;
        n_cmp++;
        if ({irq, err_valid, err_chan} !== {1'b0, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL irq_disable: got irq=%b v=%b chan=%0d want 0/1/2", irq, err_valid, err_chan);
        end
        intr_en = 1'b1;
        #1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_enable: got %b want 1", irq);
        end
    endtask

    task automatic test_clear_alone();
        err_clr = 1'b1;
        tick();
        idle_inputs();
        n_cmp++;
        if ({err_valid, err_svc, err_svc_cnt, irq} !== '0) begin
            n_fail++;
            $display("FAIL clear_alone: got v=%b svc=%b cnt=%0d irq=%b want 0/0/0/0",
                     err_valid, err_svc, err_svc_cnt, irq);
        end
    endtask

    task automatic test_multi();
        set_ev(1, 1'b1, 34'h1_0000_0010, 8'd11, 9'd21);
        set_ev(2, 1'b1, 34'h1_0000_0020, 8'd12, 9'd22);
        set_ev(3, 1'b1, 34'h1_0000_0030, 8'd13, 9'd23);
        tick();
        idle_inputs();
        n_cmp++;
        if ({err_valid, err_chan, err_svc_cnt, err_svc, err_eid, err_rrid}
            !== {1'b1, 2'd1, 8'd2, 1'b1, 9'd21, 8'd11}) begin
            n_fail++;
            $display("FAIL multi_prio: got v=%b chan=%0d cnt=%0d svc=%b eid=%0d rrid=%0d want 1/1/2/1/21/11",
                     err_valid, err_chan, err_svc_cnt, err_svc, err_eid, err_rrid);
        end
    endtask

    task automatic test_unqualified();
        set_ev(0, 1'b0, 34'h0_0000_0100, 8'd1, 9'd1);
        tick();
        idle_inputs();
        n_cmp++;
        if ({err_svc_cnt, err_chan} !== {8'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL unqual_held: got cnt=%0d chan=%0d want 2/1", err_svc_cnt, err_chan);
        end
        err_clr = 1'b1;
        tick();
        idle_inputs();
        set_ev(0, 1'b0, 34'h0_0000_0100, 8'd1, 9'd1);
        tick();
        idle_inputs();
        n_cmp++;
        if ({err_valid, err_svc_cnt} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL unqual_idle: got v=%b cnt=%0d want 0/0", err_valid, err_svc_cnt);
        end
    endtask

    task automatic test_saturate();
        set_ev(0, 1'b1, 34'h0_0000_4000, 8'd9, 9'd33);
        tick();
        idle_inputs();
        set_ev(1, 1'b1, 34'h0_0000_5000, 8'd10, 9'd44);
        for (int k = 0; k < 10; k++) tick();
        n_cmp++;
        if (err_svc_cnt !== 8'd10) begin
            n_fail++;
            $display("FAIL svc_count10: got %0d want 10", err_svc_cnt);
        end
        for (int k = 0; k < 290; k++) tick();
        idle_inputs();
        n_cmp++;
        if ({err_svc_cnt, err_svc} !== {8'd255, 1'b1}) begin
            n_fail++;
            $display("FAIL svc_saturate: got cnt=%0d svc=%b want 255/1", err_svc_cnt, err_svc);
        end
        n_cmp++;
        if ({err_chan, err_eid, err_rrid, err_reqaddr} !== {2'd0, 9'd33, 8'd9, 34'h0_0000_4000}) begin
            n_fail++;
            $display("FAIL svc_record_frozen: got chan=%0d eid=%0d rrid=%0d addr=%h want 0/33/9/000004000",
                     err_chan, err_eid, err_rrid, err_reqaddr);
        end
        set_ev(0, 1'b1, 34'h0_0000_4000, 8'd9, 9'd33);
        set_ev(2, 1'b1, 34'h0_0000_4000, 8'd9, 9'd33);
        tick();
        idle_inputs();
        n_cmp++;
        if (err_svc_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL svc_no_wrap: got %0d want 255", err_svc_cnt);
        end
    endtask

    task automatic test_clear_event();
        err_clr = 1'b1;
        set_ev(3, 1'b1, 34'h2_0000_0000, 8'd77, 9'h1FF);
        tick();
        idle_inputs();
        n_cmp++;
        if ({err_valid, err_chan, err_eid, err_svc_cnt, err_svc, err_rrid}
            !== {1'b1, 2'd3, 9'h1FF, 8'd0, 1'b0, 8'd77}) begin
            n_fail++;
            $display("FAIL clear_event: got v=%b chan=%0d eid=%h cnt=%0d svc=%b rrid=%0d want 1/3/1ff/0/0/77",
                     err_valid, err_chan, err_eid, err_svc_cnt, err_svc, err_rrid);
        end
        err_clr = 1'b1;
        set_ev(0, 1'b1, 34'h0_0000_0008, 8'd3, 9'd4);
        set_ev(3, 1'b1, 34'h0_0000_000C, 8'd6, 9'd8);
        tick();
        idle_inputs();
        n_cmp++;
        if ({err_valid, err_chan, err_eid, err_svc_cnt} !== {1'b1, 2'd0, 9'd4, 8'd1}) begin
            n_fail++;
            $display("FAIL clear_event2: got v=%b chan=%0d eid=%0d cnt=%0d want 1/0/4/1",
                     err_valid, err_chan, err_eid, err_svc_cnt);
        end
        test_clear_alone();
    endtask

    task automatic test_async_reset();
        set_ev(1, 1'b1, 34'h0_1234_5678, 8'd2, 9'd99);
        tick();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({err_valid, irq, err_chan, err_eid, err_rrid, err_reqaddr, err_svc_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b irq=%b chan=%0d eid=%0d rrid=%0d addr=%h cnt=%0d want all 0",
                     err_valid, irq, err_chan, err_eid, err_rrid, err_reqaddr, err_svc_cnt);
        end
        set_ev(2, 1'b1, 34'h0_0000_0ABC, 8'd8, 9'd15);
        tick();
        n_cmp++;
        if (err_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_event: got v=%b want 0", err_valid);
        end
        rst = 1'b0;
        tick();
        idle_inputs();
        n_cmp++;
        if ({err_valid, err_chan, err_eid, err_rrid, irq} !== {1'b1, 2'd2, 9'd15, 8'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_capture: got v=%b chan=%0d eid=%0d rrid=%0d irq=%b want 1/2/15/8/1",
                     err_valid, err_chan, err_eid, err_rrid, irq);
        end
    endtask

    initial begin
        idle_inputs();
        intr_en = 1'b1;
        test_reset();
        test_single();
        test_irq_enable();
        test_clear_alone();
        test_multi();
        test_unqualified();
        test_saturate();
        test_clear_event();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/iopmp_err_capture.md
# iopmp_err_capture

Error-record block of the IOPMP. Consumes the per-channel `error_report_t` and `entry_violated_index` streams produced by the IOPMP checker array, latches the first violation into a software-visible error record (ERR_INFO / ERR_REQADDR / ERR_REQID), and counts subsequent unrecorded violations. It holds the record until software clears it and drives the IOPMP interrupt. It sits between the checker array and the IOPMP register file.

## Interface
- `IOPMPNumChan`, 4: number of checked request channels.
- `SvcWidth`, 8: width of the subsequent-violation counter.
- `ChanIdxW`, `max(1,$clog2(IOPMPNumChan))`: channel index width (derived; not overridable).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock domain; reset is asynchronous and active-high.
- `req_valid_i`  in  `[IOPMPNumChan]` x 1  channel j presents a checked request this cycle.
- `iopmp_error_report_i`  in  `[IOPMPNumChan]` x `error_report_t`  per-channel checker report.
- `entry_violated_index_i`  in  `[IOPMPNumChan]` x 9  violated entry index.
- `err_clr_i`  in  1  single-cycle pulse from register file (write-1 to ERR_INFO.v).
- `intr_en_i`  in  1  ERR_CFG.ie.
- `err_valid_o`  out  1  ERR_INFO.v, a record is held.
- `err_etype_o`  out  `error_type`  captured etype.
- `err_ttype_o`  out  `transaction_type`  captured ttype.
- `err_reqaddr_o`  out  34  captured ERR_REQADDR.
- `err_reqaddrh_o`  out  32  captured ERR_REQADDRH.
- `err_rrid_o`  out  `SourceWidth`  captured ERR_REQID.rrid.
- `err_eid_o`  out  9  captured entry index.
- `err_chan_o`  out  `ChanIdxW`  channel that produced the record.
- `err_svc_o`  out  1  at least one subsequent violation was not recorded.
- `err_svc_cnt_o`  out  `SvcWidth`  count of unrecorded violations, saturating.
- `irq_o`  out  1  interrupt.

## Operation
- Event: `fail[j] = req_valid_i[j] & iopmp_error_report_i[j].iopmp_fail`. When `req_valid_i[j]`=0, channel j is ignored regardless of report contents.
- `nfail` = popcount(fail), range 0..IOPMPNumChan.
- Selection: fixed priority; the lowest-indexed failing channel wins.
- Two states, encoded by `err_valid_o`: IDLE (0) and HELD (1).
- IDLE with nfail>0:
  - Register the winner's etype, ttype, ERR_REQADDR, ERR_REQADDRH, rrid and `entry_violated_index_i` (not the report eid field).
  - Register the channel index.
  - Go to HELD.
  - `svc_cnt` <= nfail-1.
- HELD with nfail>0: record fields frozen; `svc_cnt` += nfail.
- `svc_cnt` arithmetic is done at SvcWidth+ChanIdxW+1 bits, then saturated at 2^SvcWidth-1. It never wraps.
- `err_svc_o` = (`svc_cnt` != 0).
- `err_clr_i`:
  - In HELD with nfail=0: go to IDLE and zero `svc_cnt`. Record fields keep their stale values but are don't-care while v=0.
  - In IDLE: no effect.
- Simultaneous clear and event, either state: the clear applies first. The new event is captured as from IDLE (new record, `svc_cnt`=nfail-1, v stays/becomes 1). No violation is lost across a clear.
- `irq_o = err_valid_o & intr_en_i`: combinational from the flop and the input; no extra latency. Toggling `intr_en_i` never alters the record.

## Timing
- Capture latency 1 cycle: an event sampled at edge N is visible on the outputs after edge N.
- `irq_o` rises in the same cycle as `err_valid_o`.
- The clear takes effect at the edge that samples `err_clr_i`=1.
- Reset (async assert, sync-safe deassert via flop reset) takes any state to IDLE. All outputs are 0, including `err_chan_o`, `err_svc_cnt_o` and `irq_o`.
- Reset mid-HELD discards the record. Events in the cycle reset is asserted are dropped.
- No backpressure toward the checker: every cycle's events are consumed.

## Test plan
- Single event: ch2 fail, addr 0x0_8000_1000, rrid 5, eid 7 -> after 1 edge: v=1, chan=2, reqaddr=0x080001000, rrid=5, eid=7, svc=0; irq=1 with ie=1.
- Simultaneous 3 failures on ch1, ch2, ch3 in IDLE -> chan=1, svc_cnt=2, svc=1.
- Unqualified report: ch0 iopmp_fail=1 with req_valid=0 -> v stays 0; in HELD -> svc_cnt unchanged.
- HELD, 300 single-channel events -> svc_cnt saturates at 255; record unchanged.
- Clear plus event in the same cycle (HELD, ch3 fail, eid 0x1FF) -> v=1, chan=3, eid=0x1FF, svc_cnt=0. Clear alone -> v=0, svc_cnt=0, irq=0.
- Reset asserted asynchronously mid-HELD -> all outputs 0 immediately, without waiting for a clock edge; the first event after release is captured normally.
